// File: rtl/chip8_pkg.sv
// Shared definitions for the CHIP-8 timer block: defaults, timer select
// encodings and the tone-generator sizing helpers.
package chip8_pkg;

   localparam int CLOCK_FREQUENCY_DEFAULT = 50_000_000;
   localparam int TONE_HZ_DEFAULT         = 440;
   localparam int TIMER_WIDTH_DEFAULT     = 8;

   // wr_sel encodings
   localparam logic SEL_DELAY = 1'b0;
   localparam logic SEL_SOUND = 1'b1;

   // Last count value of one tone half-period (counter runs 0..half).
   function automatic int tone_half(input int clock_frequency, input int tone_hz);
      return clock_frequency / (2 * tone_hz) - 1;
   endfunction

   // Bits needed to hold 0..half; never narrower than one bit.
   function automatic int tone_counter_width(input int half);
      return (half < 1) ? 1 : $clog2(half + 1);
   endfunction

endpackage

// File: rtl/square_tone_gen.sv
// Square-wave buzzer generator. While enabled, a counter walks 0..HALF and
// flips tone_out at every wrap; when disabled the counter and output are
// cleared, so each burst begins low with a full half-period.
module square_tone_gen
   import chip8_pkg::*;
#(
   parameter int CLOCK_FREQUENCY = CLOCK_FREQUENCY_DEFAULT,
   parameter int TONE_HZ         = TONE_HZ_DEFAULT
) (
   input  logic clock_in,
   input  logic resetn,
   input  logic enable,
   output logic tone_out
);

   localparam int               HALF     = tone_half(CLOCK_FREQUENCY, TONE_HZ);
   localparam int               CNT_W    = tone_counter_width(HALF);
   localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(HALF);

   logic [CNT_W-1:0] count;

   // Half-period counter and output toggle; idle state is count=0, tone low.
   always_ff @(posedge clock_in) begin
      if (!resetn) begin
         count    <= '0;
         tone_out <= 1'b0;
      end else if (!enable) begin
         count    <= '0;
         tone_out <= 1'b0;
      end else if (count == HALF_CNT) begin
         count    <= '0;
         tone_out <= ~tone_out;
      end else begin
         count    <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/chip8_timer_unit.sv
// CHIP-8 delay and sound timers. Both count down once per 60 Hz tick and
// saturate at zero; a CPU write to a timer takes priority over that timer's
// decrement in the same cycle. The sound timer gates the buzzer tone.
module chip8_timer_unit
   import chip8_pkg::*;
#(
   parameter int CLOCK_FREQUENCY = CLOCK_FREQUENCY_DEFAULT,
   parameter int TONE_HZ         = TONE_HZ_DEFAULT,
   parameter int TIMER_WIDTH     = TIMER_WIDTH_DEFAULT
) (
   input  logic                   clock_in,
   input  logic                   resetn,
   input  logic                   tick_60Hz,
   input  logic                   wr_en,
   input  logic                   wr_sel,
   input  logic [TIMER_WIDTH-1:0] wr_data,
   output logic [TIMER_WIDTH-1:0] delay_value,
   output logic [TIMER_WIDTH-1:0] sound_value,
   output logic                   delay_expired,
   output logic                   sound_active,
   output logic                   tone_out
);

   localparam logic [TIMER_WIDTH-1:0] ONE = TIMER_WIDTH'(1);

   logic wr_delay;
   logic wr_sound;

   // Decode which timer (if any) the CPU is loading this cycle.
   always_comb begin
      wr_delay = wr_en && (wr_sel == SEL_DELAY);
      wr_sound = wr_en && (wr_sel == SEL_SOUND);
   end

   // Delay timer: load wins over tick, otherwise decrement toward zero.
   always_ff @(posedge clock_in) begin
      if (!resetn) begin
         delay_value <= '0;
      end else if (wr_delay) begin
         delay_value <= wr_data;
      end else if (tick_60Hz && (delay_value != '0)) begin
         delay_value <= delay_value - ONE;
      end
   end

   // Expiry pulse only for a tick-driven 1 -> 0 transition, never for a load.
   always_ff @(posedge clock_in) begin
      if (!resetn) begin
         delay_expired <= 1'b0;
      end else begin
         delay_expired <= tick_60Hz && !wr_delay && (delay_value == ONE);
      end
   end

   // Sound timer: same load/decrement rules as the delay timer.
   always_ff @(posedge clock_in) begin
      if (!resetn) begin
         sound_value <= '0;
      end else if (wr_sound) begin
         sound_value <= wr_data;
      end else if (tick_60Hz && (sound_value != '0)) begin
         sound_value <= sound_value - ONE;
      end
   end

   // Buzzer is on whenever the sound timer holds a non-zero count.
   always_comb begin
      sound_active = (sound_value != '0);
   end

   square_tone_gen #(
      .CLOCK_FREQUENCY (CLOCK_FREQUENCY),
      .TONE_HZ         (TONE_HZ)
   ) u_tone (
      .clock_in (clock_in),
      .resetn   (resetn),
      .enable   (sound_active),
      .tone_out (tone_out)
   );

endmodule

// File: tb/tb_chip8_timer_unit.sv
// Directed bench for chip8_timer_unit with CLOCK_FREQUENCY=1000, TONE_HZ=100
// (5-cycle half-period). A cycle-level model tracks the timers and derives
// the tone from how long the buzzer has been continuously on.
module tb_chip8_timer_unit;
   import chip8_pkg::*;

   localparam int CLK_FREQ    = 1000;
   localparam int TONE        = 100;
   localparam int TW          = 8;
   localparam int HALF_PERIOD = 5;   // 1000 / (2*100) cycles per tone level

   logic          clock_in  = 1'b0;
   logic          resetn    = 1'b0;
   logic          tick_60Hz = 1'b0;
   logic          wr_en     = 1'b0;
   logic          wr_sel    = 1'b0;
   logic [TW-1:0] wr_data   = '0;
   logic [TW-1:0] delay_value;
   logic [TW-1:0] sound_value;
   logic          delay_expired;
   logic          sound_active;
   logic          tone_out;

   chip8_timer_unit #(
      .CLOCK_FREQUENCY (CLK_FREQ),
      .TONE_HZ         (TONE),
      .TIMER_WIDTH     (TW)
   ) dut (
      .clock_in      (clock_in),
      .resetn        (resetn),
      .tick_60Hz     (tick_60Hz),
      .wr_en         (wr_en),
      .wr_sel        (wr_sel),
      .wr_data       (wr_data),
      .delay_value   (delay_value),
      .sound_value   (sound_value),
      .delay_expired (delay_expired),
      .sound_active  (sound_active),
      .tone_out      (tone_out)
   );

   // clock / reset
   always #5 clock_in = ~clock_in;

   int n_tests  = 0;
   int n_fail   = 0;
   bit check_en = 1'b0;

   // ---------------- behavioural model ----------------
   int m_delay = 0;
   int m_sound = 0;
   int m_on    = 0;   // edges the buzzer has been continuously on
   bit m_exp   = 1'b0;
   bit m_tone  = 1'b0;

   always @(posedge clock_in) begin
      int old_delay;
      int old_sound;
      old_delay = m_delay;
      old_sound = m_sound;
      if (!resetn) begin
         m_delay = 0;
         m_sound = 0;
         m_on    = 0;
         m_exp   = 1'b0;
         m_tone  = 1'b0;
      end else begin
         if (wr_en && wr_sel == SEL_DELAY) m_delay = int'(wr_data);
         else if (tick_60Hz)               m_delay = (old_delay > 0) ? old_delay - 1 : 0;
         if (wr_en && wr_sel == SEL_SOUND) m_sound = int'(wr_data);
         else if (tick_60Hz)               m_sound = (old_sound > 0) ? old_sound - 1 : 0;
         m_exp  = (old_delay == 1) && (m_delay == 0) && !(wr_en && wr_sel == SEL_DELAY);
         m_on   = (old_sound != 0) ? m_on + 1 : 0;
         m_tone = ((m_on / HALF_PERIOD) % 2) == 1;
      end
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_tests++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // every-cycle comparison against the model, away from the rising edge
   always @(negedge clock_in) begin
      if (check_en) begin
         check("cmp_delay_value", 32'(delay_value), 32'(m_delay));
         check("cmp_sound_value", 32'(sound_value), 32'(m_sound));
         check("cmp_delay_expired", 32'(delay_expired), 32'(m_exp));
         check("cmp_sound_active", 32'(sound_active), 32'(m_sound != 0));
         check("cmp_tone_out", 32'(tone_out), 32'(m_tone));
      end
   end

   // ---------------- driver tasks ----------------
   // Hold the inputs across one rising edge; returns at the following falling edge.
   task automatic drive(input bit t, input bit we, input logic sel, input int d);
      tick_60Hz = t;
      wr_en     = we;
      wr_sel    = sel;
      wr_data   = d[TW-1:0];
      @(negedge clock_in);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, SEL_DELAY, 0);
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      int            exp_delay[5];
      int            pulses;
      int            tone_highs;
      logic [19:0]   tone_pat;

      exp_delay = '{2, 1, 0, 0, 0};
      tone_pat  = 20'b11111_00000_11111_00000;   // bit s = tone level s cycles after load

      // power-on reset
      resetn = 1'b0;
      repeat (2) @(negedge clock_in);
      check("reset_delay", 32'(delay_value), 0);
      check("reset_sound", 32'(sound_value), 0);
      check("reset_tone", 32'(tone_out), 0);
      check("reset_expired", 32'(delay_expired), 0);
      check_en = 1'b1;
      resetn   = 1'b1;

      // reset mid-run, colliding with a tick and a write
      drive(1'b0, 1'b1, SEL_DELAY, 50);
      check("load_delay_50", 32'(delay_value), 50);
      drive(1'b0, 1'b1, SEL_SOUND, 20);
      repeat (3) drive(1'b1, 1'b0, SEL_DELAY, 0);
      check("delay_after_3_ticks", 32'(delay_value), 47);
      check("sound_after_3_ticks", 32'(sound_value), 17);
      idle(4);
      resetn = 1'b0;
      drive(1'b1, 1'b1, SEL_SOUND, 99);
      check("midrun_reset_delay", 32'(delay_value), 0);
      check("midrun_reset_sound", 32'(sound_value), 0);
      check("midrun_reset_tone", 32'(tone_out), 0);
      resetn = 1'b1;
      idle(1);

      // countdown with a single expiry pulse
      drive(1'b0, 1'b1, SEL_DELAY, 3);
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0, SEL_DELAY, 0);
         check("countdown_value", 32'(delay_value), 32'(exp_delay[i]));
         check("countdown_expired", 32'(delay_expired), 32'(i == 2));
         if (delay_expired === 1'b1) pulses++;
      end
      check("countdown_pulse_count", 32'(pulses), 1);

      // write/tick collisions
      drive(1'b0, 1'b1, SEL_DELAY, 5);
      drive(1'b0, 1'b1, SEL_SOUND, 5);
      drive(1'b1, 1'b1, SEL_DELAY, 9);
      check("collide_delay_9", 32'(delay_value), 9);
      check("collide_sound_4", 32'(sound_value), 4);
      drive(1'b1, 1'b1, SEL_DELAY, 1);
      check("collide_delay_1", 32'(delay_value), 1);
      check("collide_no_pulse_a", 32'(delay_expired), 0);
      drive(1'b1, 1'b1, SEL_DELAY, 1);
      check("override_1to0_delay", 32'(delay_value), 1);
      check("override_1to0_no_pulse", 32'(delay_expired), 0);
      drive(1'b0, 1'b1, SEL_DELAY, 0);
      check("write_zero_no_pulse", 32'(delay_expired), 0);
      drive(1'b0, 1'b1, SEL_SOUND, 0);
      idle(2);

      // tone burst from sound=2
      drive(1'b0, 1'b1, SEL_SOUND, 2);
      check("tone_active_after_load", 32'(sound_active), 1);
      for (int s = 0; s < 20; s++) begin
         if (s > 0) idle(1);
         check("tone_pattern", 32'(tone_out), 32'(tone_pat[s]));
      end
      drive(1'b1, 1'b0, SEL_DELAY, 0);
      check("tone_sound_1", 32'(sound_value), 1);
      drive(1'b1, 1'b0, SEL_DELAY, 0);
      check("tone_sound_0", 32'(sound_value), 0);
      check("tone_inactive", 32'(sound_active), 0);
      idle(1);
      check("tone_low_after_expire", 32'(tone_out), 0);

      // reload keeps phase; stop by writing zero; fresh burst restarts low
      drive(1'b0, 1'b1, SEL_SOUND, 9);
      idle(7);
      check("stop_tone_high_7", 32'(tone_out), 1);
      drive(1'b0, 1'b1, SEL_SOUND, 30);
      check("reload_keeps_phase", 32'(tone_out), 1);
      idle(2);
      check("reload_phase_low_10", 32'(tone_out), 0);
      idle(5);
      check("stop_tone_high_15", 32'(tone_out), 1);
      drive(1'b0, 1'b1, SEL_SOUND, 0);
      check("stop_inactive_next", 32'(sound_active), 0);
      check("stop_tone_still_high", 32'(tone_out), 1);
      idle(1);
      check("stop_tone_low", 32'(tone_out), 0);
      drive(1'b0, 1'b1, SEL_SOUND, 1);
      for (int s = 0; s < 6; s++) begin
         if (s > 0) idle(1);
         check("restart_pattern", 32'(tone_out), 32'(tone_pat[s]));
      end
      drive(1'b1, 1'b0, SEL_DELAY, 0);
      idle(2);

      // saturation at zero
      drive(1'b0, 1'b1, SEL_DELAY, 0);
      drive(1'b0, 1'b1, SEL_SOUND, 0);
      pulses     = 0;
      tone_highs = 0;
      for (int i = 0; i < 300; i++) begin
         drive(1'b1, 1'b0, SEL_DELAY, 0);
         if (delay_expired !== 1'b0) pulses++;
         if (tone_out !== 1'b0) tone_highs++;
      end
      check("sat_delay", 32'(delay_value), 0);
      check("sat_sound", 32'(sound_value), 0);
      check("sat_no_pulse", 32'(pulses), 0);
      check("sat_no_tone", 32'(tone_highs), 0);

      check_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
